// File: rtl/v_speed_key_filter_pkg.sv
// Shared constants for the board key conditioning blocks: default timing
// parameters, key level encoding and a press-edge helper.
`timescale 1ns/100ps
package v_speed_key_filter_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 8;
    localparam int REPEAT_CYCLES_DEF   = 0;
    localparam int CNT_W_DEF           = 16;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // True when the debounced level has just moved from released to pressed.
    function automatic logic key_fell(input logic prev_lvl, input logic cur_lvl);
        return (prev_lvl == KEY_RELEASED) && (cur_lvl == KEY_PRESSED);
    endfunction

endpackage

// File: rtl/v_speed_key_filter_sync.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce counter;
// state_o only follows the key once the synced level has held long enough.
`timescale 1ns/100ps
module key_sync_filter
    import v_speed_key_filter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             state_q;
    logic             state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count disagreeing cycles; any agreeing cycle restarts qualification.
    always_comb begin
        state_d = state_q;
        cnt_d   = {CNT_W{1'b0}};
        if (s2_q != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = s2_q;
                cnt_d   = {CNT_W{1'b0}};
            end else begin
                state_d = state_q;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else begin
            state_d = state_q;
            cnt_d   = {CNT_W{1'b0}};
        end
    end

    // Synchronizer chain and filter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= KEY_RELEASED;
            s2_q    <= KEY_RELEASED;
            state_q <= KEY_RELEASED;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            s1_q    <= key_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/v_speed_key_filter.sv
// Speed-down key conditioner: debounced press produces one active-low
// single-cycle click, optionally repeated while the key stays held.
`timescale 1ns/100ps
module v_speed_key_filter
    import v_speed_key_filter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic invs,
    output logic outvs
);

    localparam logic             RPT_EN   = (REPEAT_CYCLES > 0);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

    logic             state_s;
    logic             press_s;
    logic             state_prev_q;
    logic [CNT_W-1:0] rpt_q;
    logic [CNT_W-1:0] rpt_d;
    logic             outvs_q;
    logic             outvs_d;

    key_sync_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_sync_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_i   (invs),
        .state_o (state_s)
    );

    assign press_s = key_fell(state_prev_q, state_s);

    // Press click has priority and restarts the repeat phase, so the two never coincide.
    always_comb begin
        rpt_d   = {CNT_W{1'b0}};
        outvs_d = 1'b1;
        if (press_s) begin
            rpt_d   = {CNT_W{1'b0}};
            outvs_d = 1'b0;
        end else if (RPT_EN && (state_s == KEY_PRESSED)) begin
            if (rpt_q == RPT_LAST) begin
                rpt_d   = {CNT_W{1'b0}};
                outvs_d = 1'b0;
            end else begin
                rpt_d   = rpt_q + CNT_W'(1);
                outvs_d = 1'b1;
            end
        end else begin
            rpt_d   = {CNT_W{1'b0}};
            outvs_d = 1'b1;
        end
    end

    // Edge-detect history, repeat counter and registered click output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_prev_q <= KEY_RELEASED;
            rpt_q        <= {CNT_W{1'b0}};
            outvs_q      <= 1'b1;
        end else begin
            state_prev_q <= state_s;
            rpt_q        <= rpt_d;
            outvs_q      <= outvs_d;
        end
    end

    assign outvs = outvs_q;

endmodule

// File: tb/tb_v_speed_key_filter.sv
// Self-checking bench: two DUTs (repeat off / repeat every 5) share one key
// input and are compared each cycle against a sample-window reference model.
`timescale 1ns/100ps
module tb_v_speed_key_filter;

    localparam int D    = 8;
    localparam int R1   = 5;
    localparam int MAXN = 4096;

    logic clk = 1'b0;
    logic rst_n;
    logic invs;
    logic outvs0;
    logic outvs1;

    always #10 clk = ~clk;

    v_speed_key_filter #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .invs(invs), .outvs(outvs0));

    v_speed_key_filter #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .invs(invs), .outvs(outvs1));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: per-edge key samples and debounced level since the last reset.
    bit samp_m [MAXN];
    bit st_m   [MAXN];
    int n_m        = 0;
    int last_press = -1;
    logic smp_invs = 1'b1;
    logic smp_rst  = 1'b0;
    int ge         = 0;

    int pulses0 = 0;
    int pulses1 = 0;
    bit arm_lat = 1'b0;
    int e0      = -1;
    int ep      = -1;

    function automatic bit samp_at(input int i);
        return (i < 0) ? 1'b1 : samp_m[i];
    endfunction

    function automatic bit st_at(input int i);
        return (i < 0) ? 1'b1 : st_m[i];
    endfunction

    initial forever begin
        @(posedge clk);
        smp_invs = invs;
        smp_rst  = rst_n;
        ge++;
    end

    // The level flips only when the D synced samples (two edges late) all disagree with it.
    initial forever begin
        bit flip;
        bit press;
        bit x0;
        bit x1;
        int n;
        @(negedge clk);
        if (!smp_rst) begin
            n_m        = 0;
            last_press = -1;
            if (!rst_n) begin
                check_eq("rst_out0", 32'(outvs0), 32'd1);
                check_eq("rst_out1", 32'(outvs1), 32'd1);
            end
        end else if (n_m < MAXN) begin
            n = n_m;
            samp_m[n] = smp_invs;
            flip = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (samp_at(n - 2 - j) == st_at(n - 1)) flip = 1'b0;
            end
            st_m[n] = flip ? ~st_at(n - 1) : st_at(n - 1);
            press = (st_at(n - 1) == 1'b0) && (st_at(n - 2) == 1'b1);
            if (press) last_press = n;
            x0 = press ? 1'b0 : 1'b1;
            x1 = press ? 1'b0 :
                 ((st_at(n - 1) == 1'b0) && (last_press >= 0) && (n > last_press) &&
                  (((n - last_press) % R1) == 0)) ? 1'b0 : 1'b1;
            n_m = n + 1;
            check_eq("out0", 32'(outvs0), 32'(x0));
            check_eq("out1", 32'(outvs1), 32'(x1));
        end
        if (rst_n) begin
            if (outvs0 === 1'b0) pulses0++;
            if (outvs1 === 1'b0) pulses1++;
        end
        if (arm_lat && smp_rst && (smp_invs == 1'b0) && (e0 < 0)) e0 = ge;
        if (arm_lat && (outvs0 === 1'b0) && (ep < 0)) ep = ge;
    end

    task automatic seg(input logic lvl, input int ns);
        invs = lvl;
        #(ns);
    endtask

    initial begin
        int p0;
        int p1;
        logic lvl;
        int dur;
        invs  = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #99;
        check_eq("rst_hold0", 32'(outvs0), 32'd1);
        check_eq("rst_hold1", 32'(outvs1), 32'd1);
        #100.1 rst_n = 1'b1;
        #4.9;
        seg(1'b1, 200);

        p0 = pulses0;
        seg(1'b0, 10); seg(1'b1, 100); seg(1'b0, 80); seg(1'b1, 300);
        check_eq("glitch_clicks", 32'(pulses0 - p0), 32'd0);

        p0 = pulses0; e0 = -1; ep = -1; arm_lat = 1'b1;
        seg(1'b0, 400); seg(1'b1, 400);
        arm_lat = 1'b0;
        check_eq("press_clicks", 32'(pulses0 - p0), 32'd1);
        check_eq("press_lat", 32'(ep - e0), 32'(D + 2));

        p0 = pulses0;
        seg(1'b1, 10); seg(1'b0, 20); seg(1'b1, 80); seg(1'b0, 140); seg(1'b1, 400);
        check_eq("bounce_clicks", 32'(pulses0 - p0), 32'd0);

        p0 = pulses0;
        seg(1'b0, 300); seg(1'b1, 300); seg(1'b0, 300); seg(1'b1, 300);
        check_eq("repress_clicks", 32'(pulses0 - p0), 32'd2);

        p0 = pulses0; p1 = pulses1;
        seg(1'b0, 800); seg(1'b1, 400);
        check_eq("rpt_clicks0", 32'(pulses0 - p0), 32'd1);
        check_eq("rpt_clicks1", 32'(pulses1 - p1), 32'd8);

        repeat (80) begin
            lvl = 1'($urandom_range(0, 1));
            dur = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 30) : $urandom_range(1, 10);
            seg(lvl, dur * 10);
        end
        seg(1'b1, 400);

        // Reset lands while the press click is low; outvs must rise without waiting for clk.
        @(posedge clk);
        #5 invs = 1'b0;
        #225;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async0", 32'(outvs0), 32'd1);
        check_eq("rst_async1", 32'(outvs1), 32'd1);
        p0 = pulses0;
        #59.1 rst_n = 1'b1;
        #400;
        seg(1'b1, 400);
        check_eq("rst_repress", 32'(pulses0 - p0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
